// File: rtl/regfile_port_scheduler_if.sv
// -----------------------------------------------------------------------------
// regfile_port_scheduler_if
//
// Host parameter-bus bundle between the SPI/config bridge (master) and the
// register-file port scheduler (slave).
//
// Handshake: a request transfers on a rising clk edge where host_valid and
// host_ready are both high. The master holds host_write/host_addr/host_wdata
// stable while host_valid is high. Read data comes back later as a one-cycle
// host_rvalid pulse, with host_rdata holding its value until the next read
// completes.
//
// Signals:
//   host_valid   master->slave  request valid
//   host_write   master->slave  1 = write, 0 = read
//   host_addr    master->slave  register address
//   host_wdata   master->slave  write data
//   host_ready   slave->master  scheduler can accept a request
//   host_rvalid  slave->master  one-cycle pulse, host_rdata valid
//   host_rdata   slave->master  read result
// -----------------------------------------------------------------------------
interface regfile_port_scheduler_if #(
  parameter int REGADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     host_valid;
  logic                     host_write;
  logic [REGADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0]    host_wdata;
  logic                     host_ready;
  logic                     host_rvalid;
  logic [DATA_WIDTH-1:0]    host_rdata;

  modport master (
    output host_valid,
    output host_write,
    output host_addr,
    output host_wdata,
    input  host_ready,
    input  host_rvalid,
    input  host_rdata
  );

  modport slave (
    input  host_valid,
    input  host_write,
    input  host_addr,
    input  host_wdata,
    output host_ready,
    output host_rvalid,
    output host_rdata
  );
endinterface

// File: rtl/regfile_port_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_port_scheduler
//
// Shares the DSP register file's write port and read port B between the core
// (priority requester) and the host parameter interface. A host access waits
// in PEND for a cycle where the core leaves the needed port idle; once it has
// waited MAX_WAIT cycles without one, the core is stalled for a single cycle
// and the host takes the port.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   core_readAddrA      core read address A (always passed through)
//   core_readAddrB      core read address B
//   core_readB_used     core consumes dataB for this cycle's readAddrB
//   core_writeAddr/core_dataW/core_writeEnable  core write request
//   core_stall          core must hold and repeat its operation next cycle
//   host                host request bundle (slave side)
//   rf_readAddrA/rf_readAddrB/rf_writeAddr/rf_dataW/rf_writeEnable
//                       register file port controls (combinational muxes)
//   rf_dataB            register file read data B (1-cycle latency)
//   dbg_state_o         current FSM state (0 IDLE, 1 PEND, 2 RESP)
// -----------------------------------------------------------------------------
module regfile_port_scheduler #(
  parameter int REGADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_WAIT      = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic [REGADDR_WIDTH-1:0] core_readAddrA,
  input  logic [REGADDR_WIDTH-1:0] core_readAddrB,
  input  logic                     core_readB_used,
  input  logic [REGADDR_WIDTH-1:0] core_writeAddr,
  input  logic [DATA_WIDTH-1:0]    core_dataW,
  input  logic                     core_writeEnable,
  output logic                     core_stall,

  regfile_port_scheduler_if.slave  host,

  output logic [REGADDR_WIDTH-1:0] rf_readAddrA,
  output logic [REGADDR_WIDTH-1:0] rf_readAddrB,
  output logic [REGADDR_WIDTH-1:0] rf_writeAddr,
  output logic [DATA_WIDTH-1:0]    rf_dataW,
  output logic                     rf_writeEnable,
  input  logic [DATA_WIDTH-1:0]    rf_dataB,

  output logic [1:0]               dbg_state_o
);

  // MAX_WAIT = 0 would give a zero-width counter; keep at least one bit.
  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [WCW-1:0]           wait_cnt_q, wait_cnt_d;
  logic                     req_write_q, req_write_d;
  logic [REGADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]    req_wdata_q, req_wdata_d;
  logic                     rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  logic accept;
  logic slot_free;
  logic at_limit;
  logic grant;
  logic forced;

  // A write needs the write port, a read needs read port B; the core leaves
  // the relevant port idle when it neither writes nor consumes dataB.
  assign accept    = (state_q == IDLE) && host.host_valid;
  assign slot_free = req_write_q ? !core_writeEnable : !core_readB_used;
  assign at_limit  = (wait_cnt_q == WAIT_LIMIT);
  assign grant     = (state_q == PEND) && (slot_free || at_limit);
  assign forced    = (state_q == PEND) && !slot_free && at_limit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_write_d = host.host_write;
          req_addr_d  = host.host_addr;
          req_wdata_d = host.host_wdata;
          wait_cnt_d  = '0;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (grant) begin
          state_d = req_write_q ? IDLE : RESP;
        end else if (!at_limit) begin
          // at_limit always grants, so this saturates without wrapping.
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      RESP: begin
        // Read port B was driven with the host address last cycle; its data
        // arrives now.
        rvalid_d = 1'b1;
        rdata_d  = rf_dataB;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    host.host_ready  = (state_q == IDLE);
    host.host_rvalid = rvalid_q;
    host.host_rdata  = rdata_q;
    core_stall       = forced;
    dbg_state_o      = state_q;

    rf_readAddrA     = core_readAddrA;
    rf_readAddrB     = core_readAddrB;
    rf_writeAddr     = core_writeAddr;
    rf_dataW         = core_dataW;
    // A stalled core repeats its write next cycle, so drop it now.
    rf_writeEnable   = core_writeEnable && !forced;

    if (grant) begin
      if (req_write_q) begin
        // Register 0 is hard-wired; the write handshake completes silently.
        rf_writeEnable = (req_addr_q != '0);
        rf_writeAddr   = req_addr_q;
        rf_dataW       = req_wdata_q;
      end else begin
        rf_readAddrB   = req_addr_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  stall_only_in_pend: assert property (
    @(posedge clk) disable iff (!reset_n) core_stall |-> (state_q == PEND));

  wait_cnt_bounded: assert property (
    @(posedge clk) disable iff (!reset_n) wait_cnt_q <= WAIT_LIMIT);

  rvalid_single_pulse: assert property (
    @(posedge clk) disable iff (!reset_n) rvalid_q |=> !rvalid_q);

endmodule
